// File: rtl/facto_queue_if.sv
// Slave-bus bundle for the queued factorial accelerator: select/strobe/address/data plus interrupt.
interface facto_queue_if #(
    parameter int W = 64
);
    logic         s_sel;
    logic         s_wr;
    logic [15:0]  s_addr;
    logic [W-1:0] s_din;
    logic [W-1:0] s_dout;
    logic         interrupt;

    modport master (
        output s_sel, s_wr, s_addr, s_din,
        input  s_dout, interrupt
    );

    modport slave (
        input  s_sel, s_wr, s_addr, s_din,
        output s_dout, interrupt
    );
endinterface

// File: rtl/facto_queue_core.sv
// Queued n! accelerator: operand FIFO -> shift-add factorial engine -> result FIFO, bus-mapped.
// Optional FACTO_OVF_DET_EN: per-entry overflow bit stored above the 2W-bit result.
module facto_queue_core #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic          clk,
    input logic          reset_n,
    facto_queue_if.slave bus
);
    localparam int CW = $clog2(W);
`ifdef FACTO_OVF_DET_EN
    localparam int RW = 2*W + 1;
`else
    localparam int RW = 2*W;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, MUL, NEXT, WRITE} state_t;
    state_t state;

    logic           run, intren, cmd_ovf;
    logic [W-1:0]   cmd_mem [DEPTH];
    logic [RW-1:0]  res_mem [DEPTH];
    logic [AW-1:0]  cmd_wp, cmd_rp, res_wp, res_rp;
    logic [AW:0]    cmd_cnt, res_cnt;
    logic [CW-1:0]  bit_cnt;
    logic [W-1:0]   k, mult;
    logic [2*W-1:0] acc, mcand, addend;
    logic [2*W:0]   sum;
`ifdef FACTO_OVF_DET_EN
    logic           ovf_acc, mcand_lost;
`endif

    logic [4:0]     reg_sel;
    logic           wr_en, rd_en, clear;
    logic           cmd_full, res_full, res_nonempty;
    logic           cmd_push, cmd_pop, cmd_drop, res_push, res_pop;
    logic           last_mul, head_ovf;
    logic [W-1:0]   cmd_head;
    logic [RW-1:0]  res_head, res_word;
    logic [W-1:0]   rdata;
    logic           unused_bits;

    assign reg_sel      = bus.s_addr[7:3];
    assign wr_en        = bus.s_sel & bus.s_wr;
    assign rd_en        = bus.s_sel & ~bus.s_wr;
    assign clear        = wr_en && reg_sel == 5'd1 && bus.s_din[0];
    assign cmd_full     = cmd_cnt == (AW+1)'(DEPTH);
    assign res_full     = res_cnt == (AW+1)'(DEPTH);
    assign res_nonempty = res_cnt != '0;
    assign cmd_head     = cmd_mem[cmd_rp];
    assign res_head     = res_mem[res_rp];

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign cmd_pop  = state == LOAD;
    assign cmd_push = wr_en && reg_sel == 5'd4 && (!cmd_full || cmd_pop);
    assign cmd_drop = wr_en && reg_sel == 5'd4 && cmd_full && !cmd_pop;
    assign res_pop  = rd_en && reg_sel == 5'd6 && res_nonempty;
    assign res_push = state == WRITE && (!res_full || res_pop);

    assign last_mul = (k - W'(1)) <= W'(1);
    assign addend   = mult[0] ? mcand : '0;
    assign sum      = {1'b0, acc} + {1'b0, addend};

`ifdef FACTO_OVF_DET_EN
    assign res_word = {ovf_acc, acc};
    assign head_ovf = res_nonempty & res_head[2*W];
`else
    assign res_word = acc;
    assign head_ovf = 1'b0;
`endif

    assign unused_bits = ^{bus.s_addr[15:8], bus.s_addr[2:0], sum[2*W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            run     <= 1'b0;
            intren  <= 1'b0;
            cmd_ovf <= 1'b0;
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (wr_en && reg_sel == 5'd0) run    <= bus.s_din[0];
            if (wr_en && reg_sel == 5'd3) intren <= bus.s_din[0];
            if (clear) begin
                state   <= IDLE;
                cmd_ovf <= 1'b0;
                cmd_wp  <= '0;
                cmd_rp  <= '0;
                cmd_cnt <= '0;
                res_wp  <= '0;
                res_rp  <= '0;
                res_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                if (cmd_drop) cmd_ovf <= 1'b1;
                if (cmd_push) cmd_wp <= cmd_wp + AW'(1);
                if (cmd_pop)  cmd_rp <= cmd_rp + AW'(1);
                if (res_push) res_wp <= res_wp + AW'(1);
                if (res_pop)  res_rp <= res_rp + AW'(1);
                case ({cmd_push, cmd_pop})
                    2'b10:   cmd_cnt <= cmd_cnt + (AW+1)'(1);
                    2'b01:   cmd_cnt <= cmd_cnt - (AW+1)'(1);
                    default: ;
                endcase
                case ({res_push, res_pop})
                    2'b10:   res_cnt <= res_cnt + (AW+1)'(1);
                    2'b01:   res_cnt <= res_cnt - (AW+1)'(1);
                    default: ;
                endcase
                case (state)
                    IDLE:  if (run && cmd_cnt != '0) state <= LOAD;
                    LOAD:  state <= (cmd_head < W'(2)) ? WRITE : MUL;
                    MUL: begin
                        if (bit_cnt == CW'(W-1)) begin
                            bit_cnt <= '0;
                            state   <= NEXT;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    NEXT:  state <= last_mul ? WRITE : MUL;
                    WRITE: if (res_push) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Datapath: acc accumulates acc*k one multiplier bit per MUL cycle, LSB first.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wp] <= bus.s_din;
        if (res_push) res_mem[res_wp] <= res_word;
        case (state)
            LOAD: begin
                k     <= cmd_head;
                mult  <= cmd_head;
                mcand <= (2*W)'(1);
                acc   <= (cmd_head < W'(2)) ? (2*W)'(1) : '0;
`ifdef FACTO_OVF_DET_EN
                ovf_acc    <= 1'b0;
                mcand_lost <= 1'b0;
`endif
            end
            MUL: begin
                acc   <= sum[2*W-1:0];
                mcand <= mcand << 1;
                mult  <= mult >> 1;
`ifdef FACTO_OVF_DET_EN
                ovf_acc    <= ovf_acc | sum[2*W] | (mult[0] & mcand_lost);
                mcand_lost <= mcand_lost | mcand[2*W-1];
`endif
            end
            NEXT: begin
                k <= k - W'(1);
                if (!last_mul) begin
                    mult  <= k - W'(1);
                    mcand <= acc;
                    acc   <= '0;
`ifdef FACTO_OVF_DET_EN
                    mcand_lost <= 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (reg_sel)
                5'd0: rdata[0] = run;
                5'd2: begin
                    rdata[0]         = res_nonempty;
                    rdata[1]         = state != IDLE;
                    rdata[2]         = cmd_full;
                    rdata[3]         = cmd_ovf;
                    rdata[4]         = head_ovf;
                    rdata[AW+8:8]    = cmd_cnt;
                    rdata[AW+16:16]  = res_cnt;
                end
                5'd3: rdata[0] = intren;
                5'd5: if (res_nonempty) rdata = res_head[2*W-1:W];
                5'd6: if (res_nonempty) rdata = res_head[W-1:0];
                default: ;
            endcase
        end
    end

    assign bus.s_dout    = rdata;
    assign bus.interrupt = intren & res_nonempty;
endmodule
